decoder_5to32: RTL and testbench

DECODER_5TO32 -- requirements
Module: decoder_5to32

---
 rtl/decoder_5to32_if.sv | 29 ++
 rtl/decoder_5to32.sv | 43 ++++
 tb/tb_decoder_5to32.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_5to32_if.sv
// Bus bundle for the 5-to-32 decoder: index/enable in, live and captured decodes out.
// The requester drives in5/en (master); the decoder drives the decode outputs (slave).
interface decoder_5to32_if;
   logic [4:0]  in5;
   logic        en;
   logic [31:0] out32;
   logic [31:0] out32_q;
   logic        valid_q;
   logic [4:0]  idx_q;

   // No handshake: en is a capture strobe, sampled on every rising edge with no back-pressure.
   modport master (
      output in5,
      output en,
      input  out32,
      input  out32_q,
      input  valid_q,
      input  idx_q
   );

   modport slave (
      input  in5,
      input  en,
      output out32,
      output out32_q,
      output valid_q,
      output idx_q
   );
endinterface

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder with a live combinational decode and an en-captured registered copy.
// Optional macro DECODER_ZERO_MASK_EN forces bit 0 low on both decodes (hardwired register x0).
module decoder_5to32 (
   input  logic            clk,
   input  logic            rst_n,
   decoder_5to32_if.slave  bus
);

   logic [31:0] w_onehot;
   logic [31:0] w_decode;
   logic [31:0] r_out32_q;
   logic [4:0]  r_idx_q;
   logic        r_valid_q;

   always_comb begin
      w_onehot = 32'd1 << bus.in5;
      w_decode = w_onehot;
`ifdef DECODER_ZERO_MASK_EN
      w_decode[0] = 1'b0;
`else
      w_decode[0] = w_onehot[0];
`endif
   end

   // Registered copy only moves on an enabled edge, so in5 wiggles between edges never reach it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out32_q <= 32'd0;
         r_idx_q   <= 5'd0;
         r_valid_q <= 1'b0;
      end else if (bus.en) begin
         r_out32_q <= w_decode;
         r_idx_q   <= bus.in5;
         r_valid_q <= 1'b1;
      end
   end

   assign bus.out32   = w_decode;
   assign bus.out32_q = r_out32_q;
   assign bus.idx_q   = r_idx_q;
   assign bus.valid_q = r_valid_q;

endmodule

// File: tb/tb_decoder_5to32.sv
// Directed self-checking bench for decoder_5to32 (works with or without DECODER_ZERO_MASK_EN).
module tb_decoder_5to32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   decoder_5to32_if bus ();

   decoder_5to32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_dec(input int idx);
      logic [31:0] v;
      v = 32'd0;
      v[idx] = 1'b1;
`ifdef DECODER_ZERO_MASK_EN
      v[0] = 1'b0;
`endif
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.in5 = 5'd7;
      #2;
      n_checks++;
      if (bus.out32_q !== 32'h0) begin n_fail++; $display("FAIL reset_out32_q got=%h exp=%h", bus.out32_q, 32'h0); end
      n_checks++;
      if (bus.valid_q !== 1'b0) begin n_fail++; $display("FAIL reset_valid_q got=%b exp=0", bus.valid_q); end
      n_checks++;
      if (bus.idx_q !== 5'd0) begin n_fail++; $display("FAIL reset_idx_q got=%0d exp=0", bus.idx_q); end
      n_checks++;
      if (bus.out32 !== 32'h0000_0080) begin n_fail++; $display("FAIL reset_live_out32 got=%h exp=%h", bus.out32, 32'h0000_0080); end
      // Enable held high across a clock edge in reset must not capture anything.
      bus.en = 1'b1;
      tick();
      n_checks++;
      if (bus.valid_q !== 1'b0) begin n_fail++; $display("FAIL reset_en_ignored got=%b exp=0", bus.valid_q); end
      bus.en = 1'b0;
      rst_n  = 1'b1;
      tick();
   endtask

   task automatic test_comb_sweep();
      for (int i = 0; i < 32; i++) begin
         bus.in5 = 5'(i);
         #1;
         n_checks++;
         if (bus.out32 !== exp_dec(i)) begin
            n_fail++;
            $display("FAIL sweep_out32[%0d] got=%h exp=%h", i, bus.out32, exp_dec(i));
         end
`ifndef DECODER_ZERO_MASK_EN
         n_checks++;
         if ($countones(bus.out32) != 1) begin
            n_fail++;
            $display("FAIL sweep_popcount[%0d] got=%0d exp=1", i, $countones(bus.out32));
         end
`endif
      end
   endtask

   task automatic test_capture_hold();
      bus.en  = 1'b1;
      bus.in5 = 5'd31;
      tick();
      n_checks++;
      if (bus.out32_q !== 32'h8000_0000) begin n_fail++; $display("FAIL cap31_out32_q got=%h exp=%h", bus.out32_q, 32'h8000_0000); end
      n_checks++;
      if (bus.idx_q !== 5'd31) begin n_fail++; $display("FAIL cap31_idx_q got=%0d exp=31", bus.idx_q); end
      n_checks++;
      if (bus.valid_q !== 1'b1) begin n_fail++; $display("FAIL cap31_valid_q got=%b exp=1", bus.valid_q); end
      bus.en  = 1'b0;
      bus.in5 = 5'd3;
      #1;
      n_checks++;
      if (bus.out32 !== 32'h0000_0008) begin n_fail++; $display("FAIL hold_live_out32 got=%h exp=%h", bus.out32, 32'h0000_0008); end
      // Several edges with en low and in5 moving between them: captured state must not budge.
      for (int k = 0; k < 4; k++) begin
         tick();
         bus.in5 = 5'(k * 5 + 2);
         #2;
         n_checks++;
         if (bus.out32_q !== 32'h8000_0000 || bus.idx_q !== 5'd31 || bus.valid_q !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_edge%0d got=%h/%0d/%b exp=80000000/31/1", k, bus.out32_q, bus.idx_q, bus.valid_q);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_seq [3];
`ifdef DECODER_ZERO_MASK_EN
      exp_seq[0] = 32'h0;
`else
      exp_seq[0] = 32'h1;
`endif
      exp_seq[1] = 32'h2;
      exp_seq[2] = 32'h4;
      bus.en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in5 = 5'(i);
         tick();
         n_checks++;
         if (bus.out32_q !== exp_seq[i] || bus.idx_q !== 5'(i) || bus.valid_q !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_step%0d got=%h/%0d/%b exp=%h/%0d/1", i, bus.out32_q, bus.idx_q, bus.valid_q, exp_seq[i], i);
         end
      end
      bus.en = 1'b0;
   endtask

   task automatic test_zero_index();
      bus.en  = 1'b1;
      bus.in5 = 5'd0;
      #1;
      n_checks++;
      if (bus.out32 !== exp_dec(0)) begin n_fail++; $display("FAIL zero_live got=%h exp=%h", bus.out32, exp_dec(0)); end
      tick();
      n_checks++;
      if (bus.out32_q !== exp_dec(0) || bus.idx_q !== 5'd0 || bus.valid_q !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_capture got=%h/%0d/%b exp=%h/0/1", bus.out32_q, bus.idx_q, bus.valid_q, exp_dec(0));
      end
      bus.en  = 1'b0;
      bus.in5 = 5'd1;
      #1;
      n_checks++;
      if (bus.out32 !== 32'h0000_0002) begin n_fail++; $display("FAIL one_live got=%h exp=%h", bus.out32, 32'h0000_0002); end
   endtask

   task automatic test_midstream_reset();
      bus.en  = 1'b1;
      bus.in5 = 5'd9;
      tick();
      n_checks++;
      if (bus.out32_q !== 32'h0000_0200) begin n_fail++; $display("FAIL mid_cap9 got=%h exp=%h", bus.out32_q, 32'h0000_0200); end
      bus.en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out32_q !== 32'h0 || bus.valid_q !== 1'b0 || bus.idx_q !== 5'd0) begin
         n_fail++;
         $display("FAIL mid_async_clear got=%h/%0d/%b exp=0/0/0", bus.out32_q, bus.idx_q, bus.valid_q);
      end
      bus.in5 = 5'd12;
      #1;
      n_checks++;
      if (bus.out32 !== 32'h0000_1000) begin n_fail++; $display("FAIL mid_live_in_reset got=%h exp=%h", bus.out32, 32'h0000_1000); end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (bus.out32_q !== 32'h0 || bus.valid_q !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_after_release got=%h/%b exp=0/0", bus.out32_q, bus.valid_q);
      end
      bus.en  = 1'b1;
      bus.in5 = 5'd4;
      tick();
      n_checks++;
      if (bus.out32_q !== 32'h0000_0010 || bus.idx_q !== 5'd4 || bus.valid_q !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_recapture got=%h/%0d/%b exp=00000010/4/1", bus.out32_q, bus.idx_q, bus.valid_q);
      end
      bus.en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_comb_sweep();
      test_capture_hold();
      test_back_to_back();
      test_zero_index();
      test_midstream_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
